// File: rtl/avgpool_seq_if.sv
// Read port into the input feature-map buffer plus the valid/ready write port
// toward the next layer's buffer, as seen from the pooling controller.
interface avgpool_seq_if #(
   parameter int ADDR_W = 16
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [15:0]       rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_data;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output rd_en, rd_addr, out_valid, out_data, out_addr,
      input  rd_data, out_ready
   );

   modport slave (
      input  rd_en, rd_addr, out_valid, out_data, out_addr,
      output rd_data, out_ready
   );
endinterface

// File: rtl/avgpool_seq.sv
// 2x2 average pooling controller: walks each channel in row-major window order,
// fetches four signed pixels per window and emits floor(sum/4) one window at a time.
module avgpool_seq #(
   parameter int WIDTH    = 28,
   parameter int HEIGHT   = 28,
   parameter int CHANNELS = 1,
   parameter int ADDR_W   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   avgpool_seq_if.master pool_if
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_OUT,
      S_DONE
   } state_e;

   localparam logic [ADDR_W-1:0] IN_W    = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] IN_CH   = ADDR_W'(WIDTH * HEIGHT);
   localparam logic [ADDR_W-1:0] OUT_W   = ADDR_W'(WIDTH / 2);
   localparam logic [ADDR_W-1:0] OUT_CH  = ADDR_W'((WIDTH / 2) * (HEIGHT / 2));
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(WIDTH / 2 - 1);
   localparam logic [ADDR_W-1:0] LAST_R  = ADDR_W'(HEIGHT / 2 - 1);
   localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(CHANNELS - 1);

   state_e            state_q,    state_d;
   logic [ADDR_W-1:0] ch_q,       ch_d;
   logic [ADDR_W-1:0] r_q,        r_d;
   logic [ADDR_W-1:0] c_q,        c_d;
   logic [1:0]        k_q,        k_d;
   logic [17:0]       acc_q,      acc_d;
   logic [15:0]       out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;

   logic [ADDR_W-1:0] fetch_row;
   logic [ADDR_W-1:0] fetch_col;
   logic [ADDR_W-1:0] fetch_addr;
   logic [17:0]       pix_ext;
   logic [17:0]       win_sum;
   logic              last_win;

   // k selects the window corner: bit 1 is the row offset, bit 0 the column offset.
   assign fetch_row  = (r_q << 1) + ADDR_W'(k_q[1]);
   assign fetch_col  = (c_q << 1) + ADDR_W'(k_q[0]);
   assign fetch_addr = ch_q * IN_CH + fetch_row * IN_W + fetch_col;

   assign pix_ext  = {{2{pool_if.rd_data[15]}}, pool_if.rd_data};
   assign win_sum  = acc_q + pix_ext;
   assign last_win = (ch_q == LAST_CH) && (r_q == LAST_R) && (c_q == LAST_C);

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         r_q        <= '0;
         c_q        <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
         out_addr_q <= '0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         r_q        <= r_d;
         c_q        <= c_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
         out_addr_q <= out_addr_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a hold default first, so no path through the
      // case statement leaves a variable unassigned and infers a latch.
      state_d    = state_q;
      ch_d       = ch_q;
      r_d        = r_q;
      c_d        = c_q;
      k_d        = k_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      out_addr_d = out_addr_q;
      rd_addr_d  = rd_addr_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               ch_d    = '0;
               r_d     = '0;
               c_d     = '0;
               k_d     = '0;
            end
         end

         S_FETCH: begin
            rd_addr_d = fetch_addr;
            k_d       = k_q + 2'd1;
            // Read data trails rd_en by one cycle, so at k=0 nothing has landed yet.
            acc_d     = (k_q == 2'd0) ? '0 : win_sum;
            if (k_q == 2'd3) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            out_data_d = 16'($signed(win_sum) >>> 2);
            out_addr_d = ch_q * OUT_CH + r_q * OUT_W + c_q;
            state_d    = S_OUT;
         end

         S_OUT: begin
            if (pool_if.out_ready) begin
               k_d = '0;
               if (last_win) begin
                  state_d = S_DONE;
                  ch_d    = '0;
                  r_d     = '0;
                  c_d     = '0;
               end else begin
                  state_d = S_FETCH;
                  if (c_q == LAST_C) begin
                     c_d = '0;
                     if (r_q == LAST_R) begin
                        r_d  = '0;
                        ch_d = ch_q + 1'b1;
                     end else begin
                        r_d = r_q + 1'b1;
                     end
                  end else begin
                     c_d = c_q + 1'b1;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outside FETCH the read address holds its last driven value.
   assign pool_if.rd_en     = (state_q == S_FETCH);
   assign pool_if.rd_addr   = (state_q == S_FETCH) ? fetch_addr : rd_addr_q;
   assign pool_if.out_valid = (state_q == S_OUT);
   assign pool_if.out_data  = out_data_q;
   assign pool_if.out_addr  = out_addr_q;

   assign busy = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_OUT);
   assign done = (state_q == S_DONE);

endmodule

// File: doc/avgpool_seq.md
# avgpool_seq

Sequential controller for 2x2 average pooling. It walks an input feature map held in an external single-port buffer, fetches each 2x2 window, and averages the four 16-bit pixels. Each result goes to the next layer's buffer through a valid/ready write port. It replaces the fully parallel pooling array wherever a feature map is too large to present as a single flat bus. One window is in flight at a time.

## Interface

- WIDTH, 28, input map width in pixels
- HEIGHT, 28, input map height in pixels
- CHANNELS, 1, number of maps pooled back-to-back
- ADDR_W, 16, read/write address width; must hold CHANNELS*HEIGHT*WIDTH-1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin pooling all channels; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final output handshake
- rd_en  out  1  read request to input buffer
- rd_addr  out  ADDR_W  input address = ch*HEIGHT*WIDTH + row*WIDTH + col
- rd_data  in  16  input pixel, valid exactly one cycle after rd_en
- out_valid  out  1  pooled result available
- out_ready  in  1  downstream accepts result
- out_data  out  16  pooled pixel
- out_addr  out  ADDR_W  output address = ch*(HEIGHT/2)*(WIDTH/2) + r*(WIDTH/2) + c

## Operation

- States: IDLE, FETCH, WAIT, OUT, DONE.
- IDLE: start=1 -> FETCH with ch=r=c=0 and fetch index k=0. Otherwise stay.
- FETCH: lasts 4 cycles; rd_en=1 each cycle.
  - k=0 reads (2r,2c); k=1 reads (2r,2c+1); k=2 reads (2r+1,2c); k=3 reads (2r+1,2c+1).
  - After k=3 -> WAIT.
- Data capture: rd_data is captured the cycle after each read, so the k=0..2 data land during FETCH and the k=3 data land in WAIT.
- WAIT: lasts 1 cycle, rd_en=0. The 4th pixel is captured, the sum is formed and the result is registered into out_data/out_addr. Next state is OUT.
- Arithmetic: pixels are signed two's complement. Sum is sign-extended to 18 bits; out_data = sum[17:2], an arithmetic shift right by 2 (floor toward -inf). No saturation is needed.
- OUT: out_valid=1. out_data and out_addr stay stable until the out_ready handshake.
  - On out_valid & out_ready, advance c, then r, then ch (row-major, channel outermost).
  - If the window just sent was the last one (ch=CHANNELS-1, r=HEIGHT/2-1, c=WIDTH/2-1) -> DONE; otherwise -> FETCH with k=0.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Odd WIDTH or HEIGHT: the last column/row is never read (floor of half-size).
- start outside IDLE (including in DONE) is ignored; nothing is queued.
- rst in any state -> IDLE on the next edge; all counters clear. An interrupted run produces no done and drives no further reads or writes.

## Timing

- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_addr=0.
- Start acceptance: start sampled high in IDLE at edge T gives rd_en=1 and busy=1 from cycle T+1.
- First window: out_valid rises at T+6.
- Throughput: with out_ready held high, each window takes 6 cycles (4 FETCH + 1 WAIT + 1 OUT). Each stalled cycle adds 1.
- Total run with out_ready=1: 6*CHANNELS*(HEIGHT/2)*(WIDTH/2) cycles from the first FETCH, plus 1 cycle for DONE.
- rd_addr changes only in FETCH. Its value in other states is don't-care but must be deterministic (held).
- out_valid never drops without a handshake. Exception: rst.

## Test plan

- 4x4 map, CHANNELS=1, pixels = address value (0..15), out_ready=1 -> outputs 2, 4, 10, 12 at out_addr 0..3. done pulses once; 24 cycles from the first FETCH to the last handshake.
- Signed floor: window {-1,-2,0,0} -> out_data=0xFFFF (-1). Window {0x7FFF x4} -> 0x7FFF. Window {0x8000 x4} -> 0x8000.
- Backpressure: hold out_ready=0 for 5 cycles on window 1 -> out_valid stays high, out_data/out_addr are stable, rd_en stays 0, and window 1 is emitted exactly once.
- CHANNELS=2, 4x4 -> rd_addr spans 0..31, out_addr spans 0..7, and the channel 1 first read is at address 16.
- Odd size: 5x5 -> 4 outputs; rd_addr never hits row 4 or column 4.
- rst asserted mid-FETCH of window 2 -> all outputs are 0 next cycle and there is no done pulse. A new start then runs cleanly from window 0.
